// File: rtl/reg_bus_pkg.sv
// Shared types and sizing helpers for the register-bus arbiter slice.
// No logic of its own; imported by reg_bus_arbiter and rr_arbiter.
// Not applicable: no datapath, no flow control.
package reg_bus_pkg;

    localparam int W_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Width of the ACCESS timeout counter (counts 0 .. timeout-1).
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    // Width of a requester index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N_REQ requesters, starting the search at `start`.
// Purely combinational: grant follows req/start in the same cycle.
// No flow control; the caller decides when a grant is consumed.
module rr_arbiter
    import reg_bus_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] start,
    output logic [N_REQ-1:0]            grant,
    output logic [idx_width(N_REQ)-1:0] grant_idx,
    output logic                        grant_vld
);

    localparam int IW = idx_width(N_REQ);

    // Scan from the farthest offset back to `start` so the nearest requester wins last.
    always_comb begin
        logic [IW:0] pos;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, start} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(N_REQ)) begin
                pos = pos - (IW + 1)'(N_REQ);
            end
            if (req[pos[IW-1:0]]) begin
                grant              = '0;
                grant[pos[IW-1:0]] = 1'b1;
                grant_idx          = pos[IW-1:0];
                grant_vld          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register bus between N_REQ requesters, round-robin, one access at a time.
// req->done 3 cycles with prompt ack, 4 cycles per back-to-back access, TIMEOUT+2 on abort.
// Requesters hold req until their done pulse; a stalled decoder is cut off by the timeout.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_wr_rd_s,
    input  logic [N_REQ*W_WIDTH-1:0] req_addr,
    input  logic [N_REQ*W_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]         done,
    output logic [W_WIDTH-1:0]       rsp_rdata,
    output logic                     rsp_err,
    output logic                     sel_en,
    output logic                     wr_rd_s,
    output logic [W_WIDTH-1:0]       addr,
    output logic [W_WIDTH-1:0]       wdata,
    input  logic                     ack,
    input  logic [W_WIDTH-1:0]       rd_data
);

    localparam int            IW       = idx_width(N_REQ);
    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [IW-1:0]        ptr, ptr_nxt;        // first requester looked at on the next pick
    logic [IW-1:0]        winner, winner_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 setup, setup_nxt;    // first ACCESS cycle, decoders cannot ack yet
    logic                 sel_en_nxt, wr_rd_s_nxt, rsp_err_nxt;
    logic [W_WIDTH-1:0]   addr_nxt, wdata_nxt, rsp_rdata_nxt;
    logic [N_REQ-1:0]     done_nxt;

    logic [N_REQ-1:0]     grant;
    logic [IW-1:0]        grant_idx;
    logic                 grant_vld;
    logic                 grant_wr;
    logic [W_WIDTH-1:0]   grant_addr, grant_wdata;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req       (req),
        .start     (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // AND-OR select of the winning requester's access fields.
    always_comb begin
        grant_wr    = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_wr    = grant_wr    | req_wr_rd_s[i];
                grant_addr  = grant_addr  | req_addr[i*W_WIDTH +: W_WIDTH];
                grant_wdata = grant_wdata | req_wdata[i*W_WIDTH +: W_WIDTH];
            end
        end
    end

    // Next-state and next registered-output values of the access sequencer.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        winner_nxt    = winner;
        cnt_nxt       = cnt;
        setup_nxt     = setup;
        sel_en_nxt    = sel_en;
        wr_rd_s_nxt   = wr_rd_s;
        addr_nxt      = addr;
        wdata_nxt     = wdata;
        done_nxt      = '0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    winner_nxt  = grant_idx;
                    wr_rd_s_nxt = grant_wr;
                    addr_nxt    = grant_addr;
                    wdata_nxt   = grant_wdata;
                    sel_en_nxt  = 1'b1;
                    cnt_nxt     = '0;
                    setup_nxt   = 1'b1;
                    state_nxt   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                setup_nxt = 1'b0;
                if (ack) begin
                    rsp_rdata_nxt    = wr_rd_s ? '0 : rd_data;
                    rsp_err_nxt      = 1'b0;
                    sel_en_nxt       = 1'b0;
                    done_nxt[winner] = 1'b1;
                    state_nxt        = ST_DONE;
                end else if (!setup) begin
                    if (cnt == CNT_LAST) begin
                        rsp_rdata_nxt    = '0;
                        rsp_err_nxt      = 1'b1;
                        sel_en_nxt       = 1'b0;
                        done_nxt[winner] = 1'b1;
                        state_nxt        = ST_DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                ptr_nxt   = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer and all outputs registered; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            winner    <= '0;
            cnt       <= '0;
            setup     <= 1'b0;
            sel_en    <= 1'b0;
            wr_rd_s   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            winner    <= winner_nxt;
            cnt       <= cnt_nxt;
            setup     <= setup_nxt;
            sel_en    <= sel_en_nxt;
            wr_rd_s   <= wr_rd_s_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
            done      <= done_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios then random multi-requester traffic.
// Transaction-level model predicts winner, completion cycle, read data and errors.
// Decoder model acks a configurable number of cycles after sel_en rises.
module tb_reg_bus_arbiter;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     req_wr_rd_s;
    logic [N*W-1:0]   req_addr;
    logic [N*W-1:0]   req_wdata;
    logic [N-1:0]     done;
    logic [W-1:0]     rsp_rdata;
    logic             rsp_err;
    logic             sel_en;
    logic             wr_rd_s;
    logic [W-1:0]     addr;
    logic [W-1:0]     wdata;
    logic             ack;
    logic [W-1:0]     rd_data;

    always #5 clk = ~clk;

    reg_bus_arbiter #(
        .W_WIDTH (W),
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_wr_rd_s (req_wr_rd_s),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .done        (done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .sel_en      (sel_en),
        .wr_rd_s     (wr_rd_s),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rd_data     (rd_data)
    );

    int total = 0;
    int bad   = 0;

    // Register map of the decoders behind the bus.
    function automatic bit is_mapped(input logic [7:0] a);
        return (a < 8'h40) && (a != 8'h05);
    endfunction

    function automatic logic [7:0] preload(input logic [7:0] a);
        return (a == 8'h02) ? 8'h3C : 8'(a * 8'd7 + 8'd3);
    endfunction

    // ---------------- decoder environment ----------------
    logic [7:0] dec_mem [256];
    logic       load;
    int         lat_cfg;
    int         sel_cnt;
    int         wr_strobes;
    logic       ack_r;
    logic [7:0] rdq;
    logic       stray_ack;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) dec_mem[i] <= preload(8'(i));
            wr_strobes <= 0;
            sel_cnt    <= 0;
            ack_r      <= 1'b0;
            rdq        <= 8'h00;
        end else begin
            sel_cnt <= sel_en ? sel_cnt + 1 : 0;
            ack_r   <= 1'b0;
            if (sel_en && is_mapped(addr) && sel_cnt == lat_cfg - 1) begin
                ack_r <= 1'b1;
                rdq   <= dec_mem[addr];
                if (wr_rd_s) begin
                    dec_mem[addr] <= wdata;
                    wr_strobes    <= wr_strobes + 1;
                end
            end
        end
    end

    assign ack     = ack_r | stray_ack;
    assign rd_data = ack_r ? rdq : (stray_ack ? 8'hEE : 8'h00);

    // ---------------- reference model state ----------------
    logic [7:0] ref_mem [256];
    bit         pend    [N];
    logic       p_wr    [N];
    logic [7:0] p_addr  [N];
    logic [7:0] p_wdata [N];
    int         p_lat   [N];
    int         exp_next;
    int         exp_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]             = pend[i];
            req_wr_rd_s[i]     = p_wr[i];
            req_addr[i*W +: W]  = p_addr[i];
            req_wdata[i*W +: W] = p_wdata[i];
        end
    endtask

    task automatic set_req(input int r, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input int lat);
        pend[r]    = 1'b1;
        p_wr[r]    = wr;
        p_addr[r]  = a;
        p_wdata[r] = d;
        p_lat[r]   = lat;
        drive();
    endtask

    task automatic rand_req(input int r);
        logic [7:0] a;
        if ($urandom_range(0, 7) == 0) a = 8'h70 | 8'($urandom_range(0, 15));
        else                           a = 8'($urandom_range(0, 63));
        set_req(r, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                int'($urandom_range(1, 4)));
    endtask

    // Called at the falling edge of the idle cycle in which requests are presented.
    // Returns at the falling edge of the idle cycle after the done pulse.
    task automatic run_txn(input string tag, input bit keep, output int w);
        int         exp_k;
        int         got;
        bit         ok;
        logic [7:0] a;
        logic [7:0] exp_rd;
        logic [N-1:0] exp_done;
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (w < 0 && pend[(exp_next + i) % N]) w = (exp_next + i) % N;
        end
        if (w < 0) w = 0;
        a      = p_addr[w];
        ok     = is_mapped(a) && (p_lat[w] <= TO);
        exp_k  = ok ? p_lat[w] + 2 : TO + 2;
        exp_rd = (ok && !p_wr[w]) ? ref_mem[a] : 8'h00;
        if (ok && p_wr[w]) begin
            ref_mem[a] = p_wdata[w];
            exp_wr++;
        end
        exp_done    = '0;
        exp_done[w] = 1'b1;
        lat_cfg     = p_lat[w];
        got         = -1;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                stray_ack = 1'b0;
                chk({tag, " bus_start"}, 32'({sel_en, wr_rd_s, addr, wdata}),
                    32'({1'b1, p_wr[w], a, p_wdata[w]}));
            end
            if (k == exp_k - 1) chk({tag, " bus_held"}, 32'({sel_en, addr}), 32'({1'b1, a}));
            if (done !== '0) begin
                got = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(got), 32'(exp_k));
        chk({tag, " done"}, 32'(done), 32'(exp_done));
        chk({tag, " rsp"}, 32'({rsp_err, rsp_rdata, sel_en}), 32'({!ok, exp_rd, 1'b0}));
        chk({tag, " wr_strobes"}, 32'(wr_strobes), 32'(exp_wr));
        exp_next = (w + 1) % N;
        if (!keep) begin
            pend[w] = 1'b0;
            drive();
        end
        @(negedge clk);
        chk({tag, " pulse_end"}, 32'({done, sel_en}), 32'(0));
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        load      = 1'b1;
        stray_ack = 1'b0;
        lat_cfg   = 1;
        exp_next  = 0;
        exp_wr    = 0;
        req = '0; req_wr_rd_s = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = 8'h00; p_wdata[i] = 8'h00; p_lat[i] = 1;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(8'(i));
        repeat (3) @(negedge clk);
        load = 1'b0;

        chk("reset sel_en", 32'(sel_en), 32'(0));
        chk("reset wr_rd_s", 32'(wr_rd_s), 32'(0));
        chk("reset addr", 32'(addr), 32'(0));
        chk("reset wdata", 32'(wdata), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset rsp", 32'({rsp_err, rsp_rdata}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // single write, single read, read-back of the write
        set_req(0, 1'b1, 8'h04, 8'hA5, 1);
        run_txn("wr04", 1'b0, w);
        set_req(1, 1'b0, 8'h02, 8'h00, 1);
        run_txn("rd02", 1'b0, w);
        set_req(1, 1'b0, 8'h04, 8'h11, 1);
        run_txn("rd04", 1'b0, w);

        // both requesters held high: strict alternation, 4 cycles apart
        set_req(0, 1'b0, 8'h01, 8'h00, 1);
        set_req(1, 1'b0, 8'h01, 8'h00, 1);
        for (int i = 0; i < 4; i++) run_txn("contend", 1'b1, w);
        pend[1] = 1'b0;

        // unmapped access times out; a stray ack while idle must be ignored
        set_req(0, 1'b0, 8'h7F, 8'h00, 1);
        stray_ack = 1'b1;
        run_txn("timeout7f", 1'b0, w);
        set_req(0, 1'b0, 8'h02, 8'h00, 1);
        run_txn("after_to", 1'b0, w);

        // ack on the last allowed cycle, then one cycle too late, then unmapped
        set_req(1, 1'b0, 8'h10, 8'h00, TO);
        run_txn("lat_edge_ok", 1'b0, w);
        set_req(1, 1'b0, 8'h11, 8'h00, TO + 1);
        run_txn("lat_edge_late", 1'b0, w);
        set_req(1, 1'b0, 8'h05, 8'h00, 1);
        run_txn("stale_ack", 1'b0, w);

        // slow write by one requester, read back by the other
        set_req(1, 1'b1, 8'h20, 8'h5E, 3);
        run_txn("wr20", 1'b0, w);
        set_req(0, 1'b0, 8'h20, 8'h00, 2);
        run_txn("rd20", 1'b0, w);

        // reset during ACCESS: no done, reset values, requester 0 first afterwards
        set_req(0, 1'b0, 8'h01, 8'h00, 1);
        set_req(1, 1'b0, 8'h02, 8'h00, 4);
        lat_cfg = 4;
        @(negedge clk);
        chk("mid bus", 32'({sel_en, addr}), 32'({1'b1, 8'h02}));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset bus", 32'({sel_en, wr_rd_s, addr, wdata}), 32'(0));
        chk("mid reset rsp", 32'({done, rsp_err, rsp_rdata}), 32'(0));
        rst_n    = 1'b1;
        exp_next = 0;
        run_txn("post_rst0", 1'b0, w);
        run_txn("post_rst1", 1'b0, w);

        // random traffic with overlapping requests
        for (int t = 0; t < 40; t++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= pend[i];
            if (!any) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                rand_req(int'($urandom_range(0, N - 1)));
            end
            run_txn("rand", 1'b0, w);
            if ($urandom_range(0, 3) != 0) rand_req(w);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) rand_req(i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
